// File: rtl/bus_arbiter4_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
// Optional feature macro: ARB_TURNAROUND_EN (dead cycle between owners).
package bus_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // Requester index to one-hot grant pattern.
    function automatic logic [NREQ-1:0] onehot2(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter4_if.sv
// Handshake bundle between the requesters and the arbiter.
// The arbiter takes the slave view; requester logic takes the master view.
interface bus_arbiter4_if;

    logic [bus_arb_pkg::NREQ-1:0] req;
    logic [bus_arb_pkg::NREQ-1:0] gnt;
    logic [1:0]                   owner;
    logic                         grant_valid;
    logic                         busy;

    modport master (output req, input gnt, input owner, input grant_valid, input busy);
    modport slave  (input req, output gnt, output owner, output grant_valid, output busy);

endinterface

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin pick: first asserted request at or after
// last+1, wrapping modulo four. idx is meaningless when any is low.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic       any_o,
    output logic [1:0] idx_o
);

    logic [1:0] cand;

    // Scan from the farthest offset down so the nearest asserted requester wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        any_o = |req_i;
        idx_o = last_i;
        cand  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_i + 2'(k);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for four tristate bus drivers with hold timeout.
// Registered one-hot gnt feeds the bufif1 enables; at most one bit is set.
// Optional feature macro: ARB_TURNAROUND_EN inserts one dead cycle (TURN)
// between ownerships; without it the handover is back-to-back.
import bus_arb_pkg::*;

module bus_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter4_if.slave  bus
);

    localparam int CW = $clog2(MAX_HOLD) + 1;

    arb_state_e    state_q;
    logic [3:0]    gnt_q;
    logic [1:0]    owner_q;
    logic [1:0]    last_q;
    logic [CW-1:0] hold_cnt_q;
    logic [CW-1:0] hold_cnt_d;
    logic          grant_valid_q;
    logic          busy_q;

    logic          pick_any;
    logic [1:0]    pick_idx;
    logic          at_limit;
    logic          others_waiting;
    logic          release_now;

    rr_pick4 u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    // Release decision: owner dropped its request, or timed out with someone waiting.
    always_comb begin
        at_limit       = (hold_cnt_q == CW'(MAX_HOLD - 1));
        others_waiting = |(bus.req & ~onehot2(owner_q));
        release_now    = !bus.req[owner_q] || (at_limit && others_waiting);
        hold_cnt_d     = at_limit ? hold_cnt_q : hold_cnt_q + CW'(1);
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_q       <= 2'd0;
            last_q        <= 2'd3;
            hold_cnt_q    <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (pick_any) begin
                        state_q       <= GRANT;
                        gnt_q         <= onehot2(pick_idx);
                        owner_q       <= pick_idx;
                        last_q        <= pick_idx;
                        hold_cnt_q    <= '0;
                        grant_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end else begin
                        state_q       <= IDLE;
                        gnt_q         <= '0;
                        grant_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
`ifdef ARB_TURNAROUND_EN
                        state_q       <= TURN;
                        gnt_q         <= '0;
                        grant_valid_q <= 1'b0;
                        busy_q        <= 1'b1;
`else
                        if (pick_any) begin
                            state_q       <= GRANT;
                            gnt_q         <= onehot2(pick_idx);
                            owner_q       <= pick_idx;
                            last_q        <= pick_idx;
                            hold_cnt_q    <= '0;
                            grant_valid_q <= 1'b1;
                            busy_q        <= 1'b1;
                        end else begin
                            state_q       <= IDLE;
                            gnt_q         <= '0;
                            grant_valid_q <= 1'b0;
                            busy_q        <= 1'b0;
                        end
`endif
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    gnt_q         <= '0;
                    grant_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.owner       = owner_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: an ownership-level reference model
// compared on every falling edge, plus directed literal expectations.
module tb_bus_arbiter4;

    localparam int MAX_HOLD = 8;
`ifdef ARB_TURNAROUND_EN
    localparam bit TURN_EN = 1'b1;
`else
    localparam bit TURN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    bit   mon_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    bus_arbiter4_if bus ();

    bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the bus, how many cycles they have held it,
    // who was served last, and whether this is a dead handover cycle.
    int m_owner;
    int m_held;
    int m_last;
    int m_shown;
    bit m_turn;

    function automatic void grant_from(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_last + k) % 4;
            if (r[i]) begin
                m_owner = i;
                m_last  = i;
                m_shown = i;
                m_held  = 1;
                return;
            end
        end
    endfunction

    // Advance the model on each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        logic [3:0] r;
        bit others;
        r = bus.req;
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 3;
            m_shown = 0;
            m_turn  = 1'b0;
        end else if (m_owner >= 0) begin
            others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
            if (!r[m_owner] || (m_held >= MAX_HOLD && others)) begin
                m_owner = -1;
                if (TURN_EN) m_turn = 1'b1;
                else grant_from(r);
            end else begin
                m_held++;
            end
        end else begin
            m_turn = 1'b0;
            grant_from(r);
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_gnt", 32'(bus.gnt), (m_owner >= 0) ? 32'(1) << m_owner : 32'd0);
            check("mon_grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
            check("mon_busy", 32'(bus.busy), 32'((m_owner >= 0) || m_turn));
            check("mon_owner", 32'(bus.owner), 32'(m_shown));
            check("mon_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            if (bus.grant_valid === 1'b1) begin
                check("mon_owner_vs_gnt", 32'(bus.gnt), 32'(4'b0001 << bus.owner));
            end
        end
    end

    int seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        mon_en = 1'b1;
        step();
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_owner", 32'(bus.owner), 32'd0);
        check("reset_grant_valid", 32'(bus.grant_valid), 32'd0);

        // Single requester: 1-cycle latency, then release on drop.
        rst     = 1'b0;
        bus.req = 4'b0001;
        step();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        check("t1_owner", 32'(bus.owner), 32'd0);
        check("t1_grant_valid", 32'(bus.grant_valid), 32'd1);
        bus.req = 4'b0000;
        step();
        check("t1_drop_gnt", 32'(bus.gnt), 32'd0);
        check("t1_drop_busy", 32'(bus.busy), 32'(TURN_EN));
        step();
        check("t1_idle_busy", 32'(bus.busy), 32'd0);

        // All four requesting: rotation 0,1,2,3,0 with MAX_HOLD cycles each.
        rst = 1'b1;
        step();
        rst     = 1'b0;
        bus.req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            check("t2_first", 32'(bus.gnt), 32'(4'b0001 << seq[k]));
            repeat (MAX_HOLD - 1) step();
            check("t2_last", 32'(bus.gnt), 32'(4'b0001 << seq[k]));
            if (k < 4) begin
                step();
                if (TURN_EN) begin
                    check("t2_dead", 32'(bus.gnt), 32'd0);
                    step();
                end
            end
        end

        // Lone requester is never preempted.
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst     = 1'b0;
        bus.req = 4'b0100;
        step();
        for (int k = 0; k < 50; k++) begin
            check("t3_hold", 32'(bus.gnt), 32'h4);
            step();
        end

        // Owner 1 preempted once its hold count reaches MAX_HOLD-1.
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst     = 1'b0;
        bus.req = 4'b0010;
        step();
        check("t4_grant", 32'(bus.gnt), 32'h2);
        repeat (3) step();
        bus.req = 4'b1010;
        repeat (4) step();
        check("t4_still_owner", 32'(bus.gnt), 32'h2);
        step();
        if (TURN_EN) begin
            check("t4_dead", 32'(bus.gnt), 32'd0);
            step();
        end
        check("t4_next", 32'(bus.gnt), 32'h8);
        check("t4_next_owner", 32'(bus.owner), 32'd3);

        // Reset mid-grant clears gnt at that edge; priority restarts at req[0].
        rst     = 1'b1;
        bus.req = 4'b0000;
        step();
        rst     = 1'b0;
        bus.req = 4'b0010;
        step();
        check("t5_grant", 32'(bus.gnt), 32'h2);
        rst = 1'b1;
        step();
        check("t5_rst_gnt", 32'(bus.gnt), 32'd0);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        rst     = 1'b0;
        bus.req = 4'b0011;
        step();
        check("t5_first", 32'(bus.gnt), 32'h1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
